// File: rtl/but_pkg.sv
// Shared constants and helpers for the push-button conditioning block.
package but_pkg;

  // Buttons are wired active-low on the board.
  localparam logic BUT_PRESSED  = 1'b0;
  localparam logic BUT_RELEASED = 1'b1;

  // 1 ms of stability at the 12 MHz fabric clock.
  localparam int DEB_CYCLES_12MHZ_1MS = 12000;

  // Width of a stability counter that must reach n-1; never narrower than one bit.
  function automatic int deb_cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/but_debounce_ch.sv
// One button channel: two-flop synchroniser, stability counter, accepted level
// and one-cycle press/release pulse flops.
module but_debounce_ch
  import but_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_12MHZ_1MS
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic out_o,
  output logic press_o,
  output logic rel_o
);

  localparam int CNT_W = deb_cnt_w(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stb_q, stb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  // Synchronise the pad, then accept a new level only after it has differed
  // from the held level for DEB_CYCLES consecutive samples.
  always_comb begin
    s1_d    = raw_i;
    s2_d    = s1_q;
    stb_d   = stb_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (s2_q == stb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stb_d   = s2_q;
      cnt_d   = '0;
      press_d = (s2_q == BUT_PRESSED);
      rel_d   = (s2_q == BUT_RELEASED);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset leaves the button released with no progress kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= BUT_RELEASED;
      s2_q    <= BUT_RELEASED;
      stb_q   <= BUT_RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      stb_q   <= stb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign out_o   = stb_q;
  assign press_o = press_q;
  assign rel_o   = rel_q;

endmodule

// File: rtl/but_debounce.sv
// Debounces N_BUT active-low push-buttons; each channel is independent.
module but_debounce
  import but_pkg::*;
#(
  parameter int N_BUT      = 4,
  parameter int DEB_CYCLES = DEB_CYCLES_12MHZ_1MS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BUT-1:0] but_raw,
  output logic [N_BUT-1:0] but_out,
  output logic [N_BUT-1:0] but_press,
  output logic [N_BUT-1:0] but_release
);

  for (genvar i = 0; i < N_BUT; i++) begin : g_ch
    but_debounce_ch #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (but_raw[i]),
      .out_o  (but_out[i]),
      .press_o(but_press[i]),
      .rel_o  (but_release[i])
    );
  end

endmodule

// File: tb/tb_but_debounce.sv
// Directed self-checking bench for but_debounce with DEB_CYCLES = 8, N_BUT = 4.
module tb_but_debounce;

  localparam int N_BUT      = 4;
  localparam int DEB_CYCLES = 8;
  localparam int LAT        = 2 + DEB_CYCLES;

  logic             clk;
  logic             rst;
  logic [N_BUT-1:0] but_raw;
  logic [N_BUT-1:0] but_out;
  logic [N_BUT-1:0] but_press;
  logic [N_BUT-1:0] but_release;

  int checks;
  int errors;
  int pulse_viol;
  logic [N_BUT-1:0] prev_press;
  logic [N_BUT-1:0] prev_rel;

  but_debounce #(
    .N_BUT(N_BUT),
    .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .but_raw    (but_raw),
    .but_out    (but_out),
    .but_press  (but_press),
    .but_release(but_release)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Background watch: press/release never together, never two cycles in a row.
  always @(negedge clk) begin
    if (|(but_press & but_release)) pulse_viol++;
    if (|(but_press & prev_press)) pulse_viol++;
    if (|(but_release & prev_rel)) pulse_viol++;
    prev_press = but_press;
    prev_rel   = but_release;
  end

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let all channels settle to the current raw levels.
  task automatic settle();
    repeat (LAT + 2) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    but_raw = 4'h0;
    repeat (3) tick();
    checks++;
    if (but_out !== 4'hF) begin
      errors++; $display("[TB] FAIL reset_out: got %h expected %h", but_out, 4'hF);
    end
    checks++;
    if (but_press !== 4'h0) begin
      errors++; $display("[TB] FAIL reset_press: got %h expected %h", but_press, 4'h0);
    end
    checks++;
    if (but_release !== 4'h0) begin
      errors++; $display("[TB] FAIL reset_release: got %h expected %h", but_release, 4'h0);
    end
    rst = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      if (k == LAT - 1) begin
        checks++;
        if (but_out !== 4'hF) begin
          errors++; $display("[TB] FAIL held_early: edge %0d got %h expected %h", k, but_out, 4'hF);
        end
      end
      if (k == LAT) begin
        checks++;
        if (but_out !== 4'h0 || but_press !== 4'hF || but_release !== 4'h0) begin
          errors++;
          $display("[TB] FAIL held_fall: out %h press %h rel %h expected 0 F 0", but_out, but_press, but_release);
        end
      end
      if (k == LAT + 1) begin
        checks++;
        if (but_press !== 4'h0) begin
          errors++; $display("[TB] FAIL held_pulse_len: press %h expected 0", but_press);
        end
      end
    end
  endtask

  task automatic test_clean_press();
    int fall_edge;
    int press_edge;
    int press_cnt;
    logic rel_seen;
    but_raw = 4'hF;
    settle();
    fall_edge = 0; press_edge = 0; press_cnt = 0; rel_seen = 1'b0;
    but_raw = 4'hE;
    for (int k = 1; k <= LAT + 4; k++) begin
      tick();
      if (fall_edge == 0 && but_out[0] == 1'b0) fall_edge = k;
      if (but_press[0]) begin
        press_cnt++;
        press_edge = k;
      end
      if (|but_release) rel_seen = 1'b1;
    end
    checks++;
    if (fall_edge != LAT) begin
      errors++; $display("[TB] FAIL press_latency: got %0d expected %0d", fall_edge, LAT);
    end
    checks++;
    if (press_cnt != 1 || press_edge != LAT) begin
      errors++; $display("[TB] FAIL press_pulse: count %0d at %0d expected 1 at %0d", press_cnt, press_edge, LAT);
    end
    checks++;
    if (rel_seen !== 1'b0) begin
      errors++; $display("[TB] FAIL press_no_release: got %b expected 0", rel_seen);
    end
  endtask

  task automatic test_bounce();
    int lens [4];
    int bad;
    int fall_edge;
    int press_cnt;
    lens = '{5, 2, 7, 3};
    bad = 0;
    for (int p = 0; p < 4; p++) begin
      but_raw = (p % 2 == 0) ? 4'b1100 : 4'b1110;
      for (int c = 0; c < lens[p]; c++) begin
        tick();
        if (but_out[1] !== 1'b1 || |but_press || |but_release) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("[TB] FAIL bounce_reject: %0d bad cycles expected 0", bad);
    end
    fall_edge = 0; press_cnt = 0;
    but_raw = 4'b1100;
    for (int k = 1; k <= LAT + 4; k++) begin
      tick();
      if (fall_edge == 0 && but_out[1] == 1'b0) fall_edge = k;
      if (but_press[1]) press_cnt++;
    end
    checks++;
    if (fall_edge != LAT || press_cnt != 1) begin
      errors++;
      $display("[TB] FAIL bounce_then_hold: fall at %0d pulses %0d expected %0d and 1", fall_edge, press_cnt, LAT);
    end
  endtask

  task automatic test_release();
    int rise_edge;
    int rel_cnt;
    int press_cnt;
    but_raw = 4'b1000;
    settle();
    checks++;
    if (but_out !== 4'b1000) begin
      errors++; $display("[TB] FAIL release_setup: got %b expected 1000", but_out);
    end
    rise_edge = 0; rel_cnt = 0; press_cnt = 0;
    but_raw = 4'b1100;
    for (int k = 1; k <= LAT + 4; k++) begin
      tick();
      if (rise_edge == 0 && but_out[2] == 1'b1) rise_edge = k;
      if (but_release[2]) rel_cnt++;
      if (but_press[2]) press_cnt++;
    end
    checks++;
    if (rise_edge != LAT) begin
      errors++; $display("[TB] FAIL release_latency: got %0d expected %0d", rise_edge, LAT);
    end
    checks++;
    if (rel_cnt != 1 || press_cnt != 0) begin
      errors++; $display("[TB] FAIL release_pulse: rel %0d press %0d expected 1 and 0", rel_cnt, press_cnt);
    end
  endtask

  task automatic test_simultaneous();
    but_raw = 4'b1101;
    settle();
    but_raw = 4'b0110;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      if (k == LAT - 1) begin
        checks++;
        if (but_out !== 4'b1101 || but_press !== 4'b0000 || but_release !== 4'b0000) begin
          errors++;
          $display("[TB] FAIL simul_before: out %b press %b rel %b expected 1101 0000 0000", but_out, but_press, but_release);
        end
      end
      if (k == LAT) begin
        checks++;
        if (but_out !== 4'b0110 || but_press !== 4'b1001 || but_release !== 4'b0010) begin
          errors++;
          $display("[TB] FAIL simul_edge: out %b press %b rel %b expected 0110 1001 0010", but_out, but_press, but_release);
        end
      end
      if (k == LAT + 1) begin
        checks++;
        if (but_press !== 4'b0000 || but_release !== 4'b0000) begin
          errors++; $display("[TB] FAIL simul_after: press %b rel %b expected 0000 0000", but_press, but_release);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    but_raw = 4'b0010;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (but_out !== 4'hF || but_press !== 4'h0 || but_release !== 4'h0) begin
      errors++;
      $display("[TB] FAIL midreset_async: out %h press %h rel %h expected F 0 0", but_out, but_press, but_release);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == LAT - 1) begin
        checks++;
        if (but_out !== 4'hF) begin
          errors++; $display("[TB] FAIL midreset_early: got %b expected 1111", but_out);
        end
      end
      if (k == LAT) begin
        checks++;
        if (but_out !== 4'b0010 || but_press !== 4'b1101) begin
          errors++; $display("[TB] FAIL midreset_fall: out %b press %b expected 0010 1101", but_out, but_press);
        end
      end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks = 0;
    errors = 0;
    pulse_viol = 0;
    prev_press = '0;
    prev_rel = '0;
    rst = 1'b1;
    but_raw = 4'h0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_simultaneous();
    test_reset_mid();
    checks++;
    if (pulse_viol != 0) begin
      errors++; $display("[TB] FAIL pulse_rules: %0d violations expected 0", pulse_viol);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
